usb_tx_pkt_ctrl: RTL
====================

Name: usb_tx_pkt_ctrl

Overview:
Parametrised packet-level transmit sequencer for the USB device-side TX path.
Sequences SYNC, PID, payload (from the TX FIFO) and CRC16 bytes into the byte shifter, then requests EOP.
Supports handshake, token and data packet types of variable length, with an unbounded bit-stuff stall.
Sits between the endpoint/protocol logic and the TX shifter, CRC16 generator and EOP generator.

Parameters:
MAX_PAYLOAD, 64, maximum data-packet payload in bytes.
LEN_W, $clog2(MAX_PAYLOAD+1), width of the length fields (derived; do not override).
WDOG_CYCLES, 1024, byte watchdog limit in clk cycles (used only with USB_TX_WDOG_EN).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
tx_start  in  1  start request; sampled in IDLE only
pkt_type  in  2  0=HANDSHAKE, 1=TOKEN, 2=DATA, 3=reserved; latched with tx_start
pkt_len  in  LEN_W  DATA payload byte count; latched with tx_start
fifo_empty  in  1  TX FIFO empty (first-word-fall-through FIFO)
byte_sent  in  1  shifter finished the current byte (1-cycle pulse)
tx_hold  in  1  shifter stall request (bit stuffing)
eop_done  in  1  EOP generator finished
load_enable  out  1  load shifter from the byte_sel source
byte_sel  out  3  0=SYNC, 1=PID, 2=FIFO, 3=CRC_LO, 4=CRC_HI
fifo_read  out  1  pop the TX FIFO
tx_enable  out  1  shifter run
crc_enable  out  1  feed the FIFO head byte into CRC16
crc_clear  out  1  reset CRC16
create_eop  out  1  EOP request
transmitting  out  1  packet in progress
tx_done  out  1  1-cycle completion pulse
tx_error  out  1  1-cycle error pulse
bytes_left  out  LEN_W  payload bytes remaining

Behaviour:
- rst (synchronous): state IDLE, phase SYNC, all outputs 0, bytes_left 0. Applies mid-packet; no EOP is emitted.
- States: IDLE, LOAD, SHIFT, STALL, ADVANCE, EOP, DONE. Phases: SYNC, PID, PAYLOAD, CRC_LO, CRC_HI.
- IDLE: tx_start latches pkt_type and pkt_len.
  - pkt_type 3, or DATA with pkt_len > MAX_PAYLOAD: tx_error pulse, stay IDLE.
  - Otherwise: phase SYNC, bytes_left = pkt_len (DATA), 2 (TOKEN) or 0 (HANDSHAKE), go LOAD.
- LOAD (1 cycle): load_enable=1, byte_sel=phase.
  - crc_clear=1 when phase PID.
  - phase PAYLOAD with fifo_empty=1 (underrun): no load, tx_error pulse, go EOP.
  - phase PAYLOAD otherwise: fifo_read=1; crc_enable=1 for DATA only; bytes_left decrements.
  - go SHIFT.
- SHIFT: tx_enable=1.
  - tx_hold=1: go STALL. A byte_sent in the same cycle is recorded in a pending flag (tx_hold has priority).
  - byte_sent=1 with tx_hold=0: go ADVANCE.
- STALL: tx_enable=0 for as long as tx_hold=1.
  - On tx_hold=0: go ADVANCE if the pending flag is set (clear it), else go SHIFT.
- ADVANCE (1 cycle): select the next phase, then go LOAD or EOP.
  - SYNC→PID.
  - PID→PAYLOAD if bytes_left>0; else CRC_LO for DATA (zero-length packet); else EOP.
  - PAYLOAD→PAYLOAD while bytes_left>0; else CRC_LO for DATA, or EOP for TOKEN.
  - CRC_LO→CRC_HI. CRC_HI→EOP.
- EOP: create_eop=1, held until eop_done=1, then go DONE.
- DONE: tx_done=1 for 1 cycle, go IDLE. tx_done is not asserted on an underrun abort; that path goes EOP→IDLE.
- transmitting=1 in LOAD, SHIFT, STALL, ADVANCE and EOP; 0 in IDLE and DONE.
- tx_start outside IDLE is ignored.
- Latency: tx_start to first load_enable is 1 cycle.
- Handshake wire bytes: 2. Token: 4. DATA with length N: N+4.

Optional Feature:
- Macro USB_TX_WDOG_EN.
  - Defined: a counter clears on every LOAD. It increments in SHIFT, STALL and EOP. On reaching WDOG_CYCLES: tx_error pulse, all outputs deasserted, go IDLE.
  - Undefined: no counter logic is generated; SHIFT, STALL and EOP wait indefinitely.

Decomposition:
- Package usb_tx_pkg holds:
  - pkt_type_t (HANDSHAKE, TOKEN, DATA, RSVD);
  - byte_sel_t (SEL_SYNC, SEL_PID, SEL_FIFO, SEL_CRC_LO, SEL_CRC_HI);
  - state_t;
  - phase_t;
  - localparam TOKEN_LEN=2.
- One sub-module, usb_tx_wdog (counter plus terminal-count compare), instantiated only under USB_TX_WDOG_EN.
- The FSM stays in usb_tx_pkt_ctrl.

Test Plan:
- HANDSHAKE, byte_sent every 8 cycles → byte_sel sequence 0,1; no fifo_read; create_eop until eop_done; tx_done exactly once.
- DATA pkt_len=3, FIFO holds 3 bytes → byte_sel 0,1,2,2,2,3,4; 3 fifo_read and 3 crc_enable pulses; bytes_left 3→0; tx_done.
- DATA pkt_len=0 → byte_sel 0,1,3,4; no fifo_read; crc_clear once during PID load.
- TOKEN with tx_hold high for 5 cycles overlapping byte_sent → tx_enable low for 5 cycles; the byte is not repeated; 4 loads total.
- DATA pkt_len=4, FIFO holds 2 bytes → tx_error on the 3rd payload LOAD; create_eop; no tx_done. Separately, pkt_len=65 → tx_error, transmitting stays 0.
- rst asserted mid-SHIFT → next edge all outputs 0, IDLE; the following tx_start is accepted normally. With USB_TX_WDOG_EN and WDOG_CYCLES=16, no byte_sent → tx_error at cycle 16.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB device TX packet sequencer.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    HANDSHAKE = 2'd0,
    TOKEN     = 2'd1,
    DATA      = 2'd2,
    RSVD      = 2'd3
  } pkt_type_t;

  typedef enum logic [2:0] {
    SEL_SYNC   = 3'd0,
    SEL_PID    = 3'd1,
    SEL_FIFO   = 3'd2,
    SEL_CRC_LO = 3'd3,
    SEL_CRC_HI = 3'd4
  } byte_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STALL,
    ST_ADVANCE,
    ST_EOP,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_SYNC,
    PH_PID,
    PH_PAYLOAD,
    PH_CRC_LO,
    PH_CRC_HI
  } phase_t;

  localparam int TOKEN_LEN = 2;

  function automatic byte_sel_t phase_to_sel(input phase_t ph);
    case (ph)
      PH_SYNC:    return SEL_SYNC;
      PH_PID:     return SEL_PID;
      PH_PAYLOAD: return SEL_FIFO;
      PH_CRC_LO:  return SEL_CRC_LO;
      default:    return SEL_CRC_HI;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_wdog.sv
// Per-byte watchdog: counts stalled cycles and flags the terminal count.
module usb_tx_wdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = count_en && (cnt_q == CNT_W'(WDOG_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// USB TX packet sequencer: SYNC, PID, payload and CRC16 bytes into the shifter, then EOP.
// Optional byte watchdog enabled by defining USB_TX_WDOG_EN.
module usb_tx_pkt_ctrl
  import usb_tx_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int LEN_W       = $clog2(MAX_PAYLOAD + 1)
`ifdef USB_TX_WDOG_EN
  ,
  parameter int WDOG_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [1:0]       pkt_type,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic             fifo_empty,
  input  logic             byte_sent,
  input  logic             tx_hold,
  input  logic             eop_done,
  output logic             load_enable,
  output logic [2:0]       byte_sel,
  output logic             fifo_read,
  output logic             tx_enable,
  output logic             crc_enable,
  output logic             crc_clear,
  output logic             create_eop,
  output logic             transmitting,
  output logic             tx_done,
  output logic             tx_error,
  output logic [LEN_W-1:0] bytes_left
);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  pkt_type_t        type_q, type_d;
  pkt_type_t        req_type;
  logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
  logic             pend_q, pend_d;
  logic             abort_q, abort_d;
  logic             wdog_expired;

  assign req_type   = pkt_type_t'(pkt_type);
  assign bytes_left = bytes_left_q;

`ifdef USB_TX_WDOG_EN
  logic wdog_clear, wdog_count;

  assign wdog_clear = (state_q == ST_LOAD);
  assign wdog_count = (state_q == ST_SHIFT) || (state_q == ST_STALL) || (state_q == ST_EOP);

  usb_tx_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wdog_clear),
    .count_en (wdog_count),
    .expired  (wdog_expired)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_SYNC;
      type_q       <= HANDSHAKE;
      bytes_left_q <= '0;
      pend_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      type_q       <= type_d;
      bytes_left_q <= bytes_left_d;
      pend_q       <= pend_d;
      abort_q      <= abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    type_d       = type_q;
    bytes_left_d = bytes_left_q;
    pend_d       = pend_q;
    abort_d      = abort_q;
    load_enable  = 1'b0;
    byte_sel     = 3'd0;
    fifo_read    = 1'b0;
    tx_enable    = 1'b0;
    crc_enable   = 1'b0;
    crc_clear    = 1'b0;
    create_eop   = 1'b0;
    transmitting = 1'b0;
    tx_done      = 1'b0;
    tx_error     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          if (req_type == RSVD || (req_type == DATA && pkt_len > LEN_W'(MAX_PAYLOAD))) begin
            tx_error = 1'b1;
          end else begin
            type_d  = req_type;
            phase_d = PH_SYNC;
            pend_d  = 1'b0;
            abort_d = 1'b0;
            case (req_type)
              DATA:    bytes_left_d = pkt_len;
              TOKEN:   bytes_left_d = LEN_W'(TOKEN_LEN);
              default: bytes_left_d = '0;
            endcase
            state_d = ST_LOAD;
          end
        end
      end

      // A payload load with nothing in the FIFO aborts the packet with an EOP and no tx_done.
      ST_LOAD: begin
        transmitting = 1'b1;
        if (phase_q == PH_PAYLOAD && fifo_empty) begin
          tx_error = 1'b1;
          abort_d  = 1'b1;
          state_d  = ST_EOP;
        end else begin
          load_enable = 1'b1;
          byte_sel    = phase_to_sel(phase_q);
          crc_clear   = (phase_q == PH_PID);
          if (phase_q == PH_PAYLOAD) begin
            fifo_read    = 1'b1;
            crc_enable   = (type_q == DATA);
            bytes_left_d = bytes_left_q - LEN_W'(1);
          end
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        transmitting = 1'b1;
        tx_enable    = 1'b1;
        if (tx_hold) begin
          pend_d  = byte_sent;
          state_d = ST_STALL;
        end else if (byte_sent) begin
          state_d = ST_ADVANCE;
        end
      end

      ST_STALL: begin
        transmitting = 1'b1;
        if (!tx_hold) begin
          pend_d  = 1'b0;
          state_d = pend_q ? ST_ADVANCE : ST_SHIFT;
        end
      end

      ST_ADVANCE: begin
        transmitting = 1'b1;
        state_d      = ST_LOAD;
        case (phase_q)
          PH_SYNC: phase_d = PH_PID;
          PH_PID, PH_PAYLOAD: begin
            if (bytes_left_q != '0) begin
              phase_d = PH_PAYLOAD;
            end else if (type_q == DATA) begin
              phase_d = PH_CRC_LO;
            end else begin
              state_d = ST_EOP;
            end
          end
          PH_CRC_LO: phase_d = PH_CRC_HI;
          default:   state_d = ST_EOP;
        endcase
      end

      ST_EOP: begin
        transmitting = 1'b1;
        create_eop   = 1'b1;
        if (eop_done) begin
          state_d = abort_q ? ST_IDLE : ST_DONE;
        end
      end

      ST_DONE: begin
        tx_done = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Watchdog expiry drops everything and reports an error in the same cycle.
    if (wdog_expired) begin
      load_enable  = 1'b0;
      byte_sel     = 3'd0;
      fifo_read    = 1'b0;
      tx_enable    = 1'b0;
      crc_enable   = 1'b0;
      crc_clear    = 1'b0;
      create_eop   = 1'b0;
      transmitting = 1'b0;
      tx_done      = 1'b0;
      tx_error     = 1'b1;
      pend_d       = 1'b0;
      state_d      = ST_IDLE;
    end
  end

endmodule
